// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared types and helpers for the data-memory controller.
//   dmem_state_e   : controller states (idle / waiting for ack / commit)
//   mem_size_e     : access size (byte, half, word)
//   is_misaligned  : true when an access would cross a word boundary
//   size_from_code : decode the core's 2-bit load size
//   size_from_be   : decode a right-aligned store byte-enable pattern
//   size_to_be     : right-aligned lane pattern for a given size
//   size_mask      : data mask that keeps only the bytes of a given size
// ---------------------------------------------------------------------------
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_BUSY = 2'd1,
    DS_DONE = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    MS_BYTE = 2'd0,
    MS_HALF = 2'd1,
    MS_WORD = 2'd2
  } mem_size_e;

  // A half may sit at offsets 0..2 (it stays inside one word); a word must be
  // word aligned; a byte is always fine.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      MS_HALF: return (off == 2'd3);
      MS_WORD: return (off != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

  // The unused size code 3 is treated as a word access.
  function automatic mem_size_e size_from_code(input logic [1:0] code);
    case (code)
      2'd0:    return MS_BYTE;
      2'd1:    return MS_HALF;
      default: return MS_WORD;
    endcase
  endfunction

  // Any pattern other than 0011/1111 is treated as a single byte.
  function automatic mem_size_e size_from_be(input logic [3:0] be);
    case (be)
      4'b1111: return MS_WORD;
      4'b0011: return MS_HALF;
      default: return MS_BYTE;
    endcase
  endfunction

  function automatic logic [3:0] size_to_be(input mem_size_e size);
    case (size)
      MS_WORD: return 4'b1111;
      MS_HALF: return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input mem_size_e size);
    case (size)
      MS_WORD: return 32'hFFFF_FFFF;
      MS_HALF: return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data-memory controller.
// Request side (current core request):
//   req_size, req_off, req_wdata   -> req_be_shifted, req_wdata_shifted,
//                                     req_misaligned
// Response side (access held in the controller):
//   rsp_size, rsp_off, rsp_rdata   -> rsp_rdata_aligned (right-aligned,
//                                     masked to the access size)
// ---------------------------------------------------------------------------
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  mem_size_e   req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be_shifted,
  output logic [31:0] req_wdata_shifted,
  output logic        req_misaligned,
  input  mem_size_e   rsp_size,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata_aligned
);

  // Stores move the right-aligned lanes up to the addressed byte; loads move
  // the addressed bytes back down to bit 0 and drop the neighbouring lanes.
  // Upper store-data bytes outside the enabled lanes are left as they are,
  // the byte enables keep them from being written.
  always_comb begin
    req_be_shifted    = size_to_be(req_size) << req_off;
    req_wdata_shifted = req_wdata << {req_off, 3'b000};
    req_misaligned    = is_misaligned(req_size, req_off);
    rsp_rdata_aligned = (rsp_rdata >> {rsp_off, 3'b000}) & size_mask(rsp_size);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller between the core load/store port and a word-
// addressed RAM with a req/ack handshake. Stalls the core until each access
// completes and flags misaligned or timed-out accesses.
// Ports:
//   clk, rst (sync, active high), clk_en (gates every register update)
//   core load  : i_read_req, i_read_size, i_read_addr, o_read_data
//   core store : i_write_enable, i_byte_enable, i_write_addr, i_write_data
//   core status: o_stall, o_misaligned (pulse), o_bus_error (pulse)
//   memory     : o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
//                i_mem_ack, i_mem_rdata
// ---------------------------------------------------------------------------
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 31,
  parameter int DATA_WIDTH     = 31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_read_req,
  input  logic [1:0]            i_read_size,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic                  o_bus_error,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-2:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH:0]   i_mem_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e         state_q, state_d;
  logic [CNT_W-1:0]    tmo_cnt_q;
  logic [1:0]          off_q;
  mem_size_e           size_q;

  logic                req_valid;
  logic                req_we;
  logic [ADDR_WIDTH:0] req_addr;
  mem_size_e           req_size;
  logic                req_misaligned;
  logic [3:0]          be_shifted;
  logic [31:0]         wdata_shifted;
  logic [31:0]         rdata_aligned;

  logic                start_hit;
  logic                misalign_hit;
  logic                ack_hit;
  logic                timeout_hit;

  // Pick the active core request. A store takes priority and the load that
  // arrived with it is dropped.
  always_comb begin
    req_valid = i_write_enable | i_read_req;
    req_we    = i_write_enable;
    if (i_write_enable) begin
      req_addr = i_write_addr;
      req_size = size_from_be(i_byte_enable);
    end else begin
      req_addr = i_read_addr;
      req_size = size_from_code(i_read_size);
    end
  end

  dmem_lane_align u_lane_align (
    .req_size          (req_size),
    .req_off           (req_addr[1:0]),
    .req_wdata         (i_write_data),
    .req_be_shifted    (be_shifted),
    .req_wdata_shifted (wdata_shifted),
    .req_misaligned    (req_misaligned),
    .rsp_size          (size_q),
    .rsp_off           (off_q),
    .rsp_rdata         (i_mem_rdata),
    .rsp_rdata_aligned (rdata_aligned)
  );

  // Next-state and stall logic. The stall is raised in the same cycle as a
  // valid request so the core holds its PC before the access is launched;
  // it drops in DS_DONE, which is the cycle the core commits. The ack test
  // comes before the timeout test so an ack in the last allowed cycle wins.
  always_comb begin
    state_d      = state_q;
    o_stall      = 1'b0;
    start_hit    = 1'b0;
    misalign_hit = 1'b0;
    ack_hit      = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (req_valid) begin
          if (req_misaligned) begin
            misalign_hit = 1'b1;
          end else begin
            o_stall   = 1'b1;
            start_hit = 1'b1;
            state_d   = DS_BUSY;
          end
        end
      end
      DS_BUSY: begin
        o_stall = 1'b1;
        if (i_mem_ack) begin
          ack_hit = 1'b1;
          state_d = DS_DONE;
        end else if (tmo_cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DS_DONE;
        end
      end
      DS_DONE: begin
        state_d = DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

  // State, timeout counter and all registered outputs. Reset wins over
  // clk_en; otherwise nothing moves while clk_en is low, so a pending request
  // and its stall simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DS_IDLE;
      tmo_cnt_q    <= '0;
      off_q        <= 2'd0;
      size_q       <= MS_BYTE;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_be     <= 4'b0000;
      o_mem_wdata  <= '0;
      o_read_data  <= '0;
      o_misaligned <= 1'b0;
      o_bus_error  <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      o_misaligned <= misalign_hit;
      o_bus_error  <= timeout_hit;

      if (state_q == DS_BUSY && state_d == DS_BUSY) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end

      if (start_hit) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= req_we;
        o_mem_addr  <= req_addr[ADDR_WIDTH:2];
        o_mem_be    <= be_shifted;
        o_mem_wdata <= req_we ? wdata_shifted : '0;
        off_q       <= req_addr[1:0];
        size_q      <= req_size;
      end

      if (ack_hit) begin
        o_mem_req   <= 1'b0;
        o_read_data <= rdata_aligned;
      end

      if (timeout_hit) begin
        o_mem_req   <= 1'b0;
        o_read_data <= '0;
      end

      // A rejected load must not hand stale data to the core.
      if (misalign_hit && !req_we) begin
        o_read_data <= '0;
      end
    end
  end

endmodule
